mem_access_unit: RTL and testbench

Load/store sequencer between the multicycle CPU's control/ALU-output stage and the byte-addressed data memory. Accepts one word, halfword or byte access per Start, drives the memory's address, write-enable and write-data inputs, and returns aligned, sign- or zero-extended load data. Sub-word stores run as read-modify-write because the memory always writes four bytes. Misaligned and out-of-range accesses fault without touching memory.

---
 rtl/mem_access_unit_pkg.sv | 46 ++++
 rtl/mem_lane_align.sv | 37 +++
 rtl/mem_access_unit.sv | 109 ++++++++++
 tb/tb_mem_access_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store sequencer: op codes, FSM states, access sizes.
package mem_access_unit_pkg;

    localparam int MEM_BYTES_DEFAULT = 256;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic size_e op_size(op_e op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic op_signed(op_e op);
        return (op == OP_LH) || (op == OP_LB);
    endfunction

    function automatic logic op_is_store(op_e op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts/extends a load lane and merges a store lane into a word.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  ofs,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] data,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b          = word[{ofs, 3'b000} +: 8];
        h          = word[{ofs[1], 4'b0000} +: 16];
        load_val   = word;
        store_word = data;
        case (size)
            SZ_BYTE: begin
                load_val   = {{24{sgn & b[7]}}, b};
                store_word = word;
                store_word[{ofs, 3'b000} +: 8] = data[7:0];
            end
            SZ_HALF: begin
                load_val   = {{16{sgn & h[15]}}, h};
                store_word = word;
                store_word[{ofs[1], 4'b0000} +: 16] = data[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one word/half/byte access per Start, sub-word stores as read-modify-write.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] LoadData,
    output logic [31:0] MemAddr,
    output logic        MemRW,
    output logic [31:0] MemDataIn,
    input  logic [31:0] MemDataOut
);

    state_e      state, state_n, start_state;
    op_e         op_in, op_q;
    logic [31:0] addr_q, wdata_q, load_q;
    logic        fault_q, memrw_q;
    logic        accept, bad_align, bad_range, fault_now;
    logic [31:0] lane_load, lane_store;

    assign op_in     = op_e'(Op);
    assign accept    = Start && (state == ST_IDLE || state == ST_DONE);
    assign bad_range = Addr >= 32'(MEM_BYTES);
    assign fault_now = bad_align || bad_range;

    always_comb begin
        bad_align = 1'b0;
        case (op_size(op_in))
            SZ_WORD: bad_align = Addr[1:0] != 2'b00;
            SZ_HALF: bad_align = Addr[0];
            default: bad_align = 1'b0;
        endcase
    end

    always_comb begin
        start_state = ST_RD;
        if (fault_now)
            start_state = ST_DONE;
        else if (op_in == OP_SW)
            start_state = ST_WR;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = start_state;
            ST_RD:   state_n = op_is_store(op_q) ? ST_WR : ST_DONE;
            ST_WR:   state_n = ST_DONE;
            ST_DONE: state_n = accept ? start_state : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // wdata_q holds StoreData from acceptance; for SH/SB it becomes the merged word at the end of RD.
    mem_lane_align u_align (
        .word       (MemDataOut),
        .ofs        (addr_q[1:0]),
        .size       (op_size(op_q)),
        .sgn        (op_signed(op_q)),
        .data       (wdata_q),
        .load_val   (lane_load),
        .store_word (lane_store)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= ST_IDLE;
            op_q    <= OP_LW;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            fault_q <= 1'b0;
            memrw_q <= 1'b0;
        end else begin
            state   <= state_n;
            // Registered write strobe so the memory's negedge write never sees decode glitches.
            memrw_q <= (state_n == ST_WR);
            if (accept) begin
                op_q    <= op_in;
                addr_q  <= Addr;
                wdata_q <= StoreData;
                fault_q <= fault_now;
            end else if (state == ST_RD) begin
                if (op_is_store(op_q))
                    wdata_q <= lane_store;
                else
                    load_q  <= lane_load;
            end
        end
    end

    assign Busy      = (state == ST_RD) || (state == ST_WR);
    assign Done      = (state == ST_DONE);
    assign Fault     = Done && fault_q;
    assign LoadData  = load_q;
    assign MemAddr   = {addr_q[31:2], 2'b00};
    assign MemRW     = memrw_q;
    assign MemDataIn = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit with a little-endian byte memory model.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        Reset, Start;
    logic [2:0]  Op;
    logic [31:0] Addr, StoreData;
    logic        Busy, Done, Fault, MemRW;
    logic [31:0] LoadData, MemAddr, MemDataIn, MemDataOut;

    logic [7:0] mem [0:255];
    int n_chk = 0, n_fail = 0, wr_cnt = 0, cyc = 0;

    mem_access_unit #(.MEM_BYTES(256)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .Addr(Addr),
        .StoreData(StoreData), .Busy(Busy), .Done(Done), .Fault(Fault),
        .LoadData(LoadData), .MemAddr(MemAddr), .MemRW(MemRW),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    assign MemDataOut = {mem[{MemAddr[7:2], 2'b11}], mem[{MemAddr[7:2], 2'b10}],
                         mem[{MemAddr[7:2], 2'b01}], mem[{MemAddr[7:2], 2'b00}]};

    always @(negedge CLK) begin
        if (MemRW) begin
            wr_cnt++;
            mem[{MemAddr[7:2], 2'b00}] = MemDataIn[7:0];
            mem[{MemAddr[7:2], 2'b01}] = MemDataIn[15:8];
            mem[{MemAddr[7:2], 2'b10}] = MemDataIn[23:16];
            mem[{MemAddr[7:2], 2'b11}] = MemDataIn[31:24];
        end
    end

    function automatic logic [31:0] mword(logic [31:0] a);
        return {mem[{a[7:2], 2'b11}], mem[{a[7:2], 2'b10}],
                mem[{a[7:2], 2'b01}], mem[{a[7:2], 2'b00}]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        int          lat;
        logic        flt;
        logic [31:0] load;
        logic [31:0] waddr;
        logic [31:0] word;
        int          wr;
    } vec_t;

    localparam int NV = 16;
    vec_t v [NV];

    // Start one access; return posedges from acceptance to Done, and writes seen.
    task automatic run_access(input vec_t t, output int lat, output int wr, output logic flt);
        int w0;
        @(negedge CLK);
        w0 = wr_cnt;
        Op = t.op; Addr = t.addr; StoreData = t.sdata; Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0; Op = ~t.op; Addr = ~t.addr; StoreData = ~t.sdata;
        lat = 1;
        flt = 1'b0;
        forever begin
            @(negedge CLK);
            if (Done) begin
                flt = Fault;
                break;
            end
            if (lat > 8) begin
                $display("FAIL timeout: no Done after %0d cycles", lat);
                n_fail++;
                break;
            end
            @(posedge CLK);
            lat++;
        end
        #1;
        wr = wr_cnt - w0;
    endtask

    initial begin
        int lat, wr, t1, t2, w0;
        logic flt;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        Reset = 1'b1; Start = 1'b0; Op = 3'd0; Addr = '0; StoreData = '0;

        //      op     addr    sdata         lat flt load          waddr   word          wr
        v[0]  = '{3'd5, 32'h10,  32'hDEADBEEF, 2, 1'b0, 32'h00000000, 32'h10, 32'hDEADBEEF, 1};
        v[1]  = '{3'd0, 32'h10,  32'h0,        2, 1'b0, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, 0};
        v[2]  = '{3'd7, 32'h11,  32'hFFFFFF55, 3, 1'b0, 32'hDEADBEEF, 32'h10, 32'hDEAD55EF, 1};
        v[3]  = '{3'd3, 32'h11,  32'h0,        2, 1'b0, 32'h00000055, 32'h10, 32'hDEAD55EF, 0};
        v[4]  = '{3'd3, 32'h13,  32'h0,        2, 1'b0, 32'hFFFFFFDE, 32'h10, 32'hDEAD55EF, 0};
        v[5]  = '{3'd4, 32'h13,  32'h0,        2, 1'b0, 32'h000000DE, 32'h10, 32'hDEAD55EF, 0};
        v[6]  = '{3'd3, 32'h10,  32'h0,        2, 1'b0, 32'hFFFFFFEF, 32'h10, 32'hDEAD55EF, 0};
        v[7]  = '{3'd6, 32'h12,  32'h12348001, 3, 1'b0, 32'hFFFFFFEF, 32'h10, 32'h800155EF, 1};
        v[8]  = '{3'd1, 32'h12,  32'h0,        2, 1'b0, 32'hFFFF8001, 32'h10, 32'h800155EF, 0};
        v[9]  = '{3'd2, 32'h12,  32'h0,        2, 1'b0, 32'h00008001, 32'h10, 32'h800155EF, 0};
        v[10] = '{3'd1, 32'h10,  32'h0,        2, 1'b0, 32'h000055EF, 32'h10, 32'h800155EF, 0};
        v[11] = '{3'd0, 32'h13,  32'h0,        1, 1'b1, 32'h000055EF, 32'h10, 32'h800155EF, 0};
        v[12] = '{3'd6, 32'h15,  32'hFFFF,     1, 1'b1, 32'h000055EF, 32'h14, 32'h00000000, 0};
        v[13] = '{3'd7, 32'h100, 32'hAA,       1, 1'b1, 32'h000055EF, 32'h00, 32'h00000000, 0};
        v[14] = '{3'd5, 32'hFC,  32'h12345678, 2, 1'b0, 32'h000055EF, 32'hFC, 32'h12345678, 1};
        v[15] = '{3'd4, 32'hFF,  32'h0,        2, 1'b0, 32'h00000012, 32'hFC, 32'h12345678, 0};

        // Reset held two cycles; everything must read zero during and after.
        w0 = wr_cnt;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_fault", 32'(Fault), 0);
        chk("rst_loaddata", LoadData, 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_memrw", 32'(MemRW), 0);
        chk("rst_memdatain", MemDataIn, 0);
        Reset = 1'b0;
        @(negedge CLK);
        chk("idle_busy", 32'(Busy), 0);
        chk("idle_done", 32'(Done), 0);
        chk("rst_writes", 32'(wr_cnt - w0), 0);

        for (int i = 0; i < NV; i++) begin
            run_access(v[i], lat, wr, flt);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
            chk($sformatf("v%0d_fault", i), 32'(flt), 32'(v[i].flt));
            chk($sformatf("v%0d_loaddata", i), LoadData, v[i].load);
            chk($sformatf("v%0d_memword", i), mword(v[i].waddr), v[i].word);
            chk($sformatf("v%0d_writes", i), 32'(wr), 32'(v[i].wr));
        end

        // Back-to-back: SW with Start held so the LW is taken straight from DONE.
        @(negedge CLK);
        Op = 3'd5; Addr = 32'h20; StoreData = 32'hAABBCCDD; Start = 1'b1;
        @(posedge CLK);
        #1;
        Op = 3'd0; StoreData = 32'h0;
        t1 = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (Done) begin t1 = cyc; break; end
        end
        chk("b2b_first_done", 32'(t1 >= 0), 1);
        @(posedge CLK);
        #1;
        Start = 1'b0;
        t2 = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (Done) begin t2 = cyc; break; end
        end
        chk("b2b_spacing", 32'(t2 - t1), 2);
        chk("b2b_loaddata", LoadData, 32'hAABBCCDD);
        chk("b2b_memword", mword(32'h20), 32'hAABBCCDD);

        // Reset during the RD cycle of an SB must leave the target word untouched.
        @(negedge CLK);
        w0 = wr_cnt;
        Op = 3'd7; Addr = 32'h10; StoreData = 32'hAA; Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        chk("rdrst_busy_in_rd", 32'(Busy), 1);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        chk("rdrst_busy_after", 32'(Busy), 0);
        chk("rdrst_done_after", 32'(Done), 0);
        chk("rdrst_loaddata", LoadData, 0);
        repeat (3) @(negedge CLK);
        #1;
        chk("rdrst_writes", 32'(wr_cnt - w0), 0);
        chk("rdrst_memword", mword(32'h10), 32'h800155EF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
